// File: rtl/conv11_pkg.sv
// Shared types and defaults for the 1x1 convolution sequencer.
// State encoding, default geometry and port-width helpers.
package conv11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_IN = 3'd1,
    ST_READ    = 3'd2,
    ST_MAC     = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_OUT     = 3'd5,
    ST_DONE    = 3'd6
  } conv11_state_t;

  localparam int IN_CH_DEF    = 16;
  localparam int FMAP_PIX_DEF = 64;
  localparam int PIPE_LAT_DEF = 2;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WA_W_DEF  = cw(IN_CH_DEF);
  localparam int PIX_W_DEF = cw(FMAP_PIX_DEF);

endpackage

// File: rtl/conv11_ctrl_if.sv
// Control bundle between conv11_ctrl (master) and buffer/PE/writer side (slave).
// CONV11_PERF_CNT_EN adds the stall counter outputs.
interface conv11_ctrl_if
  import conv11_pkg::*;
#(
  parameter int IN_CH    = IN_CH_DEF,
  parameter int FMAP_PIX = FMAP_PIX_DEF
);
  localparam int WA_W  = cw(IN_CH);
  localparam int PIX_W = cw(FMAP_PIX);

  logic             start;
  logic             inputbuf_load;
  logic             inputbuf_read_en;
  logic [WA_W-1:0]  weight_addr;
  logic             mac_en;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] pixel_idx;
  logic             busy;
  logic             done;
`ifdef CONV11_PERF_CNT_EN
  logic [31:0]      stall_in_cnt;
  logic [31:0]      stall_out_cnt;
`endif

  modport master (
    input  start, inputbuf_load, out_ready,
    output inputbuf_read_en, weight_addr, mac_en, acc_clear,
    output out_valid, pixel_idx, busy, done
`ifdef CONV11_PERF_CNT_EN
    , output stall_in_cnt, stall_out_cnt
`endif
  );

  modport slave (
    output start, inputbuf_load, out_ready,
    input  inputbuf_read_en, weight_addr, mac_en, acc_clear,
    input  out_valid, pixel_idx, busy, done
`ifdef CONV11_PERF_CNT_EN
    , input stall_in_cnt, stall_out_cnt
`endif
  );

endinterface

// File: rtl/conv11_flush_timer.sv
// PE pipeline drain timer: loaded on the last MAC, expires combinationally in the
// final FLUSH cycle so out_valid rises the cycle the accumulator is stable (min 1 FLUSH cycle).
module conv11_flush_timer
  import conv11_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  // Last mac_en cycle already counts toward the latency, hence PIPE_LAT-1.
  localparam int FLUSH_CYC = (PIPE_LAT > 1) ? PIPE_LAT - 1 : 1;
  localparam int CW        = cw(FLUSH_CYC);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(FLUSH_CYC - 1);
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/conv11_ctrl.sv
// 1x1 conv sequencer: per pixel reads IN_CH channels (WAIT_IN/READ/MAC), drains the PE pipe,
// then holds out_valid until out_ready; all outputs registered. CONV11_PERF_CNT_EN adds stall counters.
module conv11_ctrl
  import conv11_pkg::*;
#(
  parameter int IN_CH    = IN_CH_DEF,
  parameter int FMAP_PIX = FMAP_PIX_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input logic         clk,
  input logic         rst_n,
  conv11_ctrl_if.master bus
);
  localparam int WA_W  = cw(IN_CH);
  localparam int PIX_W = cw(FMAP_PIX);
  localparam logic [WA_W-1:0]  IC_LAST  = WA_W'(IN_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FMAP_PIX - 1);

  conv11_state_t    st_q;
  logic [WA_W-1:0]  ic_q;
  logic [PIX_W-1:0] pix_q;
  logic [WA_W-1:0]  wa_q;
  logic             rd_q, mac_q, clr_q, ov_q, busy_q, done_q;
  logic             flush_expire;

  conv11_flush_timer #(.PIPE_LAT(PIPE_LAT)) u_flush (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (st_q == ST_MAC && ic_q == IC_LAST),
    .en_i     (st_q == ST_FLUSH),
    .expire_o (flush_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      ic_q   <= '0;
      pix_q  <= '0;
      wa_q   <= '0;
      rd_q   <= 1'b0;
      mac_q  <= 1'b0;
      clr_q  <= 1'b0;
      ov_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      mac_q  <= 1'b0;
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      wa_q   <= '0;
      case (st_q)
        ST_IDLE: if (bus.start) begin
          st_q   <= ST_WAIT_IN;
          busy_q <= 1'b1;
          pix_q  <= '0;
          ic_q   <= '0;
        end
        ST_WAIT_IN: if (bus.inputbuf_load) begin
          st_q <= ST_READ;
          rd_q <= 1'b1;
          wa_q <= ic_q;
        end
        ST_READ: begin
          st_q  <= ST_MAC;
          mac_q <= 1'b1;
          clr_q <= (ic_q == '0);
        end
        ST_MAC: begin
          if (ic_q == IC_LAST) begin
            ic_q <= '0;
            st_q <= ST_FLUSH;
          end else begin
            ic_q <= ic_q + 1'b1;
            st_q <= ST_WAIT_IN;
          end
        end
        ST_FLUSH: if (flush_expire) begin
          st_q <= ST_OUT;
          ov_q <= 1'b1;
        end
        ST_OUT: if (bus.out_ready) begin
          ov_q <= 1'b0;
          if (pix_q == PIX_LAST) begin
            st_q   <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            pix_q <= pix_q + 1'b1;
            st_q  <= ST_WAIT_IN;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          st_q   <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.inputbuf_read_en = rd_q;
  assign bus.weight_addr      = wa_q;
  assign bus.mac_en           = mac_q;
  assign bus.acc_clear        = clr_q;
  assign bus.out_valid        = ov_q;
  assign bus.pixel_idx        = pix_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

`ifdef CONV11_PERF_CNT_EN
  logic [31:0] stall_in_q, stall_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_in_q  <= '0;
      stall_out_q <= '0;
    end else if (st_q == ST_IDLE && bus.start) begin
      stall_in_q  <= '0;
      stall_out_q <= '0;
    end else begin
      if (st_q == ST_WAIT_IN && !bus.inputbuf_load && stall_in_q != '1)
        stall_in_q <= stall_in_q + 32'd1;
      if (st_q == ST_OUT && !bus.out_ready && stall_out_q != '1)
        stall_out_q <= stall_out_q + 32'd1;
    end
  end

  assign bus.stall_in_cnt  = stall_in_q;
  assign bus.stall_out_cnt = stall_out_q;
`endif

endmodule

// File: tb/tb_conv11_ctrl.sv
// Directed bench for conv11_ctrl with IN_CH=4, FMAP_PIX=3, PIPE_LAT=2.
module tb_conv11_ctrl;
  import conv11_pkg::*;

  localparam int IN_CH    = 4;
  localparam int FMAP_PIX = 3;
  localparam int PIPE_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv11_ctrl_if #(.IN_CH(IN_CH), .FMAP_PIX(FMAP_PIX)) bus ();

  conv11_ctrl #(.IN_CH(IN_CH), .FMAP_PIX(FMAP_PIX), .PIPE_LAT(PIPE_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       s;
    logic       l;
    logic       r;
    logic [9:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [1:0] hs_pix[$];
  int n_chk = 0, n_pass = 0;
  int n_rd, n_mac, n_clr, n_hs, n_done;
  logic got_done;

  // {read_en, weight_addr[1:0], mac_en, acc_clear, out_valid, pixel_idx[1:0], busy, done}
  function automatic logic [9:0] outs();
    return {bus.inputbuf_read_en, bus.weight_addr, bus.mac_en, bus.acc_clear,
            bus.out_valid, bus.pixel_idx, bus.busy, bus.done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clr_counts();
    n_rd = 0; n_mac = 0; n_clr = 0; n_hs = 0; n_done = 0;
    hs_pix.delete();
  endtask

  task automatic step(input logic s, input logic l, input logic r);
    logic       ov_b;
    logic [1:0] pix_b;
    ov_b  = bus.out_valid;
    pix_b = bus.pixel_idx;
    bus.start = s; bus.inputbuf_load = l; bus.out_ready = r;
    @(posedge clk); #1;
    n_rd   += int'(bus.inputbuf_read_en);
    n_mac  += int'(bus.mac_en);
    n_clr  += int'(bus.acc_clear);
    n_done += int'(bus.done);
    if (ov_b && r) begin
      n_hs++;
      hs_pix.push_back(pix_b);
    end
  endtask

  task automatic add(input logic s, input logic l, input logic r,
                     input logic rd, input logic [1:0] wa, input logic mac, input logic clr,
                     input logic ov, input logic [1:0] pix, input logic busy, input logic done);
    vec_t v;
    v.s = s; v.l = l; v.r = r;
    v.exp = {rd, wa, mac, clr, ov, pix, busy, done};
    tbl.push_back(v);
  endtask

  initial begin
    bus.start = 1'b0; bus.inputbuf_load = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
`ifdef CONV11_PERF_CNT_EN
    check("reset_stall_in", bus.stall_in_cnt, 32'd0);
    check("reset_stall_out", bus.stall_out_cnt, 32'd0);
`endif

    // No start: load high must not be consumed.
    clr_counts();
    repeat (10) step(1'b0, 1'b1, 1'b1);
    check("idle_read_en", n_rd, 0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Pixel 0: channels every 3 cycles, 5-cycle starvation before ch2,
    // 7-cycle backpressure in OUT, stray start/ready/load ignored.
    add(1,1,1, 0,2'd0,0,0,0,2'd0,1,0);   // 0  accept start
    add(0,1,1, 1,2'd0,0,0,0,2'd0,1,0);   // 1  READ ch0
    add(0,1,0, 0,2'd0,1,1,0,2'd0,1,0);   // 2  MAC clear
    add(0,0,1, 0,2'd0,0,0,0,2'd0,1,0);   // 3  WAIT_IN ch1
    add(0,1,0, 1,2'd1,0,0,0,2'd0,1,0);   // 4
    add(0,1,0, 0,2'd0,1,0,0,2'd0,1,0);   // 5
    add(0,0,0, 0,2'd0,0,0,0,2'd0,1,0);   // 6  WAIT_IN ch2
    for (int i = 0; i < 5; i++)
      add((i == 2), 0,0, 0,2'd0,0,0,0,2'd0,1,0); // 7..11 starved
    add(0,1,0, 1,2'd2,0,0,0,2'd0,1,0);   // 12
    add(0,1,0, 0,2'd0,1,0,0,2'd0,1,0);   // 13
    add(0,0,0, 0,2'd0,0,0,0,2'd0,1,0);   // 14 WAIT_IN ch3
    add(0,1,0, 1,2'd3,0,0,0,2'd0,1,0);   // 15
    add(0,1,1, 0,2'd0,1,0,0,2'd0,1,0);   // 16 4th mac
    add(0,1,1, 0,2'd0,0,0,0,2'd0,1,0);   // 17 FLUSH
    add(0,1,1, 0,2'd0,0,0,1,2'd0,1,0);   // 18 OUT
    for (int i = 0; i < 7; i++)
      add(0,1,0, 0,2'd0,0,0,1,2'd0,1,0); // 19..25 backpressure
    add(0,1,1, 0,2'd0,0,0,0,2'd1,1,0);   // 26 accepted

    clr_counts();
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].l, tbl[i].r);
      check($sformatf("row%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
`ifdef CONV11_PERF_CNT_EN
    check("stall_in_cnt", bus.stall_in_cnt, 32'd5);
    check("stall_out_cnt", bus.stall_out_cnt, 32'd7);
`endif

    // Rest of the frame; a start mid-frame is ignored.
    got_done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step(c == 5, 1'b1, 1'b1);
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("frame_read_en", n_rd, 3 * IN_CH);
    check("frame_mac_en", n_mac, 3 * IN_CH);
    check("frame_acc_clear", n_clr, 3);
    check("frame_handshakes", n_hs, 3);
    check("frame_done_pulses", n_done, 1);
    check("busy_during_done", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 3; k++)
      check($sformatf("hs_pix%0d", k), (hs_pix.size() > k) ? 32'(hs_pix[k]) : 32'hdead, k);

    // Start arriving in DONE is ignored.
    step(1'b1, 1'b1, 1'b1);
    check("after_done_done", 32'(bus.done), 32'd0);
    check("after_done_busy", 32'(bus.busy), 32'd0);
    step(1'b0, 1'b1, 1'b1);
    check("idle_after_done_busy", 32'(bus.busy), 32'd0);
    check("idle_after_done_rd", 32'(bus.inputbuf_read_en), 32'd0);

    // Second frame: counters clear on start, then reset mid-frame.
    step(1'b1, 1'b1, 1'b1);
    check("frame2_busy", 32'(bus.busy), 32'd1);
`ifdef CONV11_PERF_CNT_EN
    check("stall_in_clear", bus.stall_in_cnt, 32'd0);
    check("stall_out_clear", bus.stall_out_cnt, 32'd0);
`endif
    repeat (7) step(1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_outs", 32'(outs()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_counts();
    repeat (10) step(1'b0, 1'b1, 1'b1);
    check("post_reset_read_en", n_rd, 0);
    check("post_reset_done", n_done, 0);
    check("post_reset_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
